// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
//  mux4_rr_arbiter_pkg
//  Shared types and constants for the 4-way round-robin arbiter/mux.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

`include "mux4_arb_defs.vh"

  typedef enum logic [0:0] {
    IDLE  = `MUX4_ARB_ST_IDLE,
    GRANT = `MUX4_ARB_ST_GRANT
  } arb_state_t;

  localparam int unsigned C_DEF_MAX_HOLD = `MUX4_ARB_DEF_MAX_HOLD;
  localparam int unsigned C_NUM_REQ      = 4;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_if.sv
// ============================================================================
//  mux4_rr_arbiter_if
//  Request/data/grant bundle between requesters and the arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 2
) ();

  logic [3:0]       req;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] x;
  logic [3:0]       grant;
  logic [1:0]       s;
  logic [WIDTH-1:0] M;
  logic             M_valid;

  modport master (
    output req, u, v, w, x,
    input  grant, s, M, M_valid
  );

  modport slave (
    input  req, u, v, w, x,
    output grant, s, M, M_valid
  );

endinterface

`default_nettype wire

// File: rtl/mux4_arb_defs.vh
// ============================================================================
//  mux4_arb_defs.vh
//  Shared FSM state encodings and default hold limit for mux4_rr_arbiter.
//  Revision: 1.0
// ============================================================================
`ifndef MUX4_ARB_DEFS_VH
`define MUX4_ARB_DEFS_VH

`define MUX4_ARB_ST_IDLE       1'b0
`define MUX4_ARB_ST_GRANT      1'b1
`define MUX4_ARB_DEF_MAX_HOLD  8

`endif

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ============================================================================
//  rr_pick4
//  Combinational round-robin pick: first set req bit after ptr, wrapping.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick4 (
  input  wire logic [3:0] req,
  input  wire logic [1:0] ptr,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Search order ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
//  mux4_rr_arbiter
//  4-way round-robin arbiter with registered grant/select and data mux.
//  Optional owner timeout enabled by defining MUX4_ARB_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = C_DEF_MAX_HOLD
) (
  input wire logic          clk,
  input wire logic          rst,
  mux4_rr_arbiter_if.slave  bus
);

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux4_rr_arbiter: MAX_HOLD out of range 1..255");
    end
  endgenerate

  arb_state_t       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       s_q, s_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             m_valid_q, m_valid_d;
  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             take_new;
  logic             force_rot;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  assign force_rot = (state_q == GRANT) && (hold_q == C_HOLD_LAST)
                     && (|(bus.req & ~grant_q));

  // Saturates at the limit so a lone owner keeps its grant indefinitely.
  always_comb begin
    hold_d = hold_q;
    if (take_new) begin
      hold_d = '0;
    end else if (state_q == GRANT && hold_q != C_HOLD_LAST) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign force_rot = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    m_valid_d = (state_q == GRANT);
    take_new  = 1'b0;

    case (s_q)
      2'd0:    m_d = bus.u;
      2'd1:    m_d = bus.v;
      2'd2:    m_d = bus.w;
      default: m_d = bus.x;
    endcase

    case (state_q)
      IDLE: begin
        take_new = pick_found;
      end
      default: begin
        // Owner leaving (or being rotated out) hands over on the same edge.
        if (!bus.req[s_q] || force_rot) begin
          if (pick_found) begin
            take_new = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
    endcase

    if (take_new) begin
      state_d = GRANT;
      grant_d = onehot4(pick_idx);
      s_d     = pick_idx;
      ptr_d   = pick_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      s_q       <= '0;
      ptr_q     <= 2'd3;
      m_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.s       = s_q;
  assign bus.M       = m_q;
  assign bus.M_valid = m_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
//  tb_mux4_rr_arbiter
//  Directed self-checking bench for mux4_rr_arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

  localparam int C_WIDTH = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mux4_rr_arbiter_if #(.WIDTH(C_WIDTH)) bus ();

  mux4_rr_arbiter #(
    .WIDTH    (C_WIDTH),
    .MAX_HOLD (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.u    = 4'hA;
    bus.v    = 4'h5;
    bus.w    = 4'hC;
    bus.x    = 4'h3;

    #12;
    check("rst_grant",   {28'b0, bus.grant}, 32'h0);
    check("rst_s",       {30'b0, bus.s}, 32'h0);
    check("rst_M",       {28'b0, bus.M}, 32'h0);
    check("rst_M_valid", {31'b0, bus.M_valid}, 32'h0);
    tick();
    rst = 1'b0;

    // First grant from reset: requester 0 has priority.
    bus.req = 4'b0101;
    tick();
    check("first_grant",   {28'b0, bus.grant}, 32'h1);
    check("first_s",       {30'b0, bus.s}, 32'h0);
    check("first_M_valid", {31'b0, bus.M_valid}, 32'h0);
    tick();
    check("first_M",       {28'b0, bus.M}, 32'hA);
    check("first_M_valid2", {31'b0, bus.M_valid}, 32'h1);

    // Owner drops, pending requester takes over with no idle cycle.
    bus.req = 4'b0100;
    tick();
    check("handover_grant", {28'b0, bus.grant}, 32'h4);
    check("handover_s",     {30'b0, bus.s}, 32'h2);
    check("handover_valid", {31'b0, bus.M_valid}, 32'h1);
    tick();
    check("handover_M",     {28'b0, bus.M}, 32'hC);
    check("handover_valid2", {31'b0, bus.M_valid}, 32'h1);

    // All four requesting from a clean reset.
    do_reset();
    bus.req = 4'b1111;
    tick();
    check("all_first", {28'b0, bus.grant}, 32'h1);
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      repeat (7) tick();
      check("hold_owner", {28'b0, bus.grant}, 32'h1 << k);
      tick();
      check("rotate",     {28'b0, bus.grant}, 32'h1 << ((k + 1) % 4));
    end
`else
    repeat (20) tick();
    check("no_timeout_hold", {28'b0, bus.grant}, 32'h1);
    bus.req = 4'b1110;
    tick();
    check("drop0_grant", {28'b0, bus.grant}, 32'h2);
`endif

    // Reset in the middle of a grant owned by requester 2.
    bus.req = 4'b0100;
    tick();
    check("pre_rst_s",     {30'b0, bus.s}, 32'h2);
    check("pre_rst_grant", {28'b0, bus.grant}, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_grant", {28'b0, bus.grant}, 32'h0);
    check("async_rst_valid", {31'b0, bus.M_valid}, 32'h0);
    check("async_rst_s",     {30'b0, bus.s}, 32'h0);
    bus.req = 4'b1111;
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_grant", {28'b0, bus.grant}, 32'h1);

    // Lone requester 3, then release to idle.
    bus.req = 4'b1000;
    tick();
    check("r3_grant", {28'b0, bus.grant}, 32'h8);
    check("r3_s",     {30'b0, bus.s}, 32'h3);
    tick();
    check("r3_M",     {28'b0, bus.M}, 32'h3);
    bus.req = 4'b0000;
    tick();
    check("idle_grant",  {28'b0, bus.grant}, 32'h0);
    check("idle_s",      {30'b0, bus.s}, 32'h3);
    check("idle_valid1", {31'b0, bus.M_valid}, 32'h1);
    tick();
    check("idle_valid0", {31'b0, bus.M_valid}, 32'h0);
    check("idle_s_hold", {30'b0, bus.s}, 32'h3);

    // A pulse that misses the decision edge must not win.
    bus.req = 4'b0010;
    #3;
    bus.req = 4'b0000;
    tick();
    check("glitch_grant", {28'b0, bus.grant}, 32'h0);

    // Search wraps from last owner 3 to requester 0.
    bus.req = 4'b1001;
    tick();
    check("wrap_grant", {28'b0, bus.grant}, 32'h1);
    check("wrap_s",     {30'b0, bus.s}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
